// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: round-robin arbiter letting NUM_MASTERS Wishbone masters share
// one slave port. Ownership is held for a whole cyc. A stall watchdog ends hung
// strobes with a forced error.
module wishbone_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [NUM_MASTERS-1:0]               m_rty_o,
    output logic [ADDR_WIDTH-1:0]                s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic                                 s_we_o,
    output logic [SELECT_WIDTH-1:0]              s_sel_o,
    output logic                                 s_stb_o,
    output logic                                 s_cyc_o,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_err_i,
    input  logic                                 s_rty_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 timeout_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        TOUT
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]       lastIdx_q;
    logic [CNT_W-1:0]       wdogCount_q;
    logic [CNT_W-1:0]       wdogCount_d;
    logic                   timeout_q;

    logic                   winValid;
    logic [IDX_W-1:0]       winIdx;
    logic                   respAny;
    logic                   stalled;
    logic                   expire;

    // Round-robin search from the slot after the last owner; the nearest requester wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        winValid = 1'b0;
        winIdx   = '0;
        cand     = '0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            cand = IDX_W'((int'(lastIdx_q) + off) % NUM_MASTERS);
            if (m_cyc_i[cand]) begin
                winValid = 1'b1;
                winIdx   = cand;
            end
        end
    end

    // Watchdog next count: only consecutive unanswered strobe cycles accumulate.
    always_comb begin
        respAny     = s_ack_i | s_err_i | s_rty_i;
        stalled     = (state_q == BUSY) && s_stb_o && !respAny;
        expire      = (TIMEOUT_CYCLES != 0) && stalled && (wdogCount_q == CNT_LAST);
        wdogCount_d = stalled ? wdogCount_q + CNT_W'(1) : '0;
    end

    // Arbitration FSM holding the registered grant, last owner, watchdog and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastIdx_q   <= LAST_RESET;
            wdogCount_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q   <= 1'b0;
                    wdogCount_q <= '0;
                    if (winValid) begin
                        state_q   <= BUSY;
                        grant_q   <= NUM_MASTERS'(1) << winIdx;
                        lastIdx_q <= winIdx;
                    end
                end
                BUSY: begin
                    if (!m_cyc_i[lastIdx_q]) begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        wdogCount_q <= '0;
                    end else if (expire) begin
                        state_q     <= TOUT;
                        timeout_q   <= 1'b1;
                        wdogCount_q <= '0;
                    end else begin
                        wdogCount_q <= wdogCount_d;
                    end
                end
                TOUT: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    timeout_q   <= 1'b0;
                    wdogCount_q <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    timeout_q   <= 1'b0;
                    wdogCount_q <= '0;
                end
            endcase
        end
    end

    // Bus mux: only the owner reaches the slave, and only the owner hears the slave.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state_q == BUSY) begin
            s_adr_o = m_adr_i[int'(lastIdx_q)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o = m_dat_i[int'(lastIdx_q)*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = m_sel_i[int'(lastIdx_q)*SELECT_WIDTH +: SELECT_WIDTH];
            s_we_o  = m_we_i[lastIdx_q];
            s_stb_o = m_stb_i[lastIdx_q];
            s_cyc_o = m_cyc_i[lastIdx_q];
            m_ack_o[lastIdx_q] = s_ack_i;
            m_err_o[lastIdx_q] = s_err_i;
            m_rty_o[lastIdx_q] = s_rty_i;
        end else if (state_q == TOUT) begin
            m_err_o[lastIdx_q] = 1'b1;
        end
    end

    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb_wishbone_arbiter: randomized batches of master requests with a scoreboard.
// Expected grant order and responses are queued when a batch is issued; a
// negedge monitor pops and compares whenever the arbiter grants or responds.
module tb_wishbone_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;
    localparam int NEVER = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  m_adr_i;
    logic [NM*DW-1:0]  m_dat_i;
    logic [NM-1:0]     m_we_i, m_stb_i, m_cyc_i;
    logic [NM*SW-1:0]  m_sel_i;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic              s_we_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_stb_o, s_cyc_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i, s_rty_i;
    logic [NM-1:0]     grant_o;
    logic              timeout_o;

    typedef struct {
        logic [NM-1:0] onehot;
        int            reqCycle;
        bit            checkLat;
    } grantT;

    typedef struct {
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [NM-1:0] rty;
        logic          tmo;
        logic          sCyc;
        logic [DW-1:0] dat;
    } respT;

    grantT grantQ[$];
    respT  respQ[$];

    logic [AW-1:0] mAdr [NM];
    logic [DW-1:0] mDat [NM];
    logic          mWe  [NM];
    logic [SW-1:0] mSel [NM];
    int            planDelay [NM];
    int            planKind  [NM];
    logic [DW-1:0] planData  [NM];
    logic [NM-1:0] pending;
    logic [NM-1:0] respSeen;
    int            stallCnt;
    int            modelLast;
    bit            monitorOn;
    bit            slaveOn;
    int            vectors = 0;
    int            miscompares = 0;
    int            cycleNo = 0;

    // Free-running clock
    always #5 clk = ~clk;

    wishbone_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_stb_i(m_stb_i),
        .m_cyc_i(m_cyc_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Pack the per-master request arrays into the flat master-side buses
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_adr_i[i*AW +: AW] = mAdr[i];
            m_dat_i[i*DW +: DW] = mDat[i];
            m_sel_i[i*SW +: SW] = mSel[i];
            m_we_i[i]           = mWe[i];
        end
        m_cyc_i = pending;
        m_stb_i = pending;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
        end
    endtask

    // One bus cycle: masters retire answered requests, the slave model answers per plan
    task automatic stepCycle();
        int o;
        @(posedge clk);
        #1;
        pending  = pending & ~respSeen;
        respSeen = '0;
        s_ack_i  = 1'b0;
        s_err_i  = 1'b0;
        s_rty_i  = 1'b0;
        s_dat_i  = $urandom;
        #1;
        if (slaveOn && s_cyc_o && s_stb_o && $onehot(grant_o)) begin
            o = 0;
            for (int k = 0; k < NM; k++) if (grant_o[k]) o = k;
            if (stallCnt == planDelay[o]) begin
                case (planKind[o])
                    0:       s_ack_i = 1'b1;
                    1:       s_err_i = 1'b1;
                    default: s_rty_i = 1'b1;
                endcase
                s_dat_i = planData[o];
            end
            stallCnt++;
        end else if (!s_cyc_o) begin
            stallCnt = 0;
            if (slaveOn && grant_o == '0 && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       s_ack_i = 1'b1;
                    1:       s_err_i = 1'b1;
                    default: s_rty_i = 1'b1;
                endcase
            end
        end
        #1;
        respSeen = m_ack_o | m_err_o | m_rty_o;
    endtask

    task automatic setMaster(input int i, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                             input logic we, input logic [SW-1:0] sel,
                             input int kind, input int delay, input logic [DW-1:0] rdata);
        mAdr[i] = adr; mDat[i] = dat; mWe[i] = we; mSel[i] = sel;
        planKind[i] = kind; planDelay[i] = delay; planData[i] = rdata;
    endtask

    task automatic randomMaster(input int i);
        int r;
        int d;
        r = $urandom_range(0, 9);
        d = (r <= 5) ? (r % 4) : (r == 6) ? TMO - 1 : (r == 7) ? NEVER : 1;
        setMaster(i, $urandom, $urandom, 1'($urandom_range(0, 1)), SW'($urandom),
                  $urandom_range(0, 2), d, $urandom);
    endtask

    task automatic doReset();
        monitorOn = 1'b0;
        slaveOn   = 1'b0;
        pending   = '0;
        rst       = 1'b1;
        repeat (2) stepCycle();
        rst = 1'b0;
        repeat (2) stepCycle();
        modelLast = NM - 1;
        monitorOn = 1'b1;
        slaveOn   = 1'b1;
    endtask

    // Issue one batch: every master in req raises cyc together and does one transfer
    task automatic applyStimulus(input logic [NM-1:0] req);
        grantT         g;
        respT          r;
        logic [NM-1:0] oh;
        int            m;
        int            start;
        int            budget;
        bit            first;
        start = modelLast;
        first = 1'b1;
        for (int off = 1; off <= NM; off++) begin
            m = (start + off) % NM;
            if (req[m]) begin
                oh = '0;
                oh[m] = 1'b1;
                g.onehot   = oh;
                g.reqCycle = cycleNo + 1;
                g.checkLat = first;
                first      = 1'b0;
                grantQ.push_back(g);
                r.ack = '0; r.err = '0; r.rty = '0; r.dat = planData[m];
                if (planDelay[m] >= TMO) begin
                    r.err = oh; r.tmo = 1'b1; r.sCyc = 1'b0;
                end else begin
                    case (planKind[m])
                        0:       r.ack = oh;
                        1:       r.err = oh;
                        default: r.rty = oh;
                    endcase
                    r.tmo = 1'b0; r.sCyc = 1'b1;
                end
                respQ.push_back(r);
                modelLast = m;
            end
        end
        pending = req;
        budget  = 0;
        while (pending != '0 && budget < 300) begin
            stepCycle();
            budget++;
        end
        if (pending != '0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL batch_done: pending %b after %0d cycles, required 0", pending, budget);
            doReset();
        end else begin
            repeat (3) stepCycle();
        end
    endtask

    // Scoreboard monitor: compares grants, bus contents and responses at each negedge
    initial begin : monitor
        logic [NM-1:0] prevGrant;
        int            curOwner;
        bit            ownerValid;
        int            stbCount;
        grantT         g;
        respT          r;
        prevGrant = '0; curOwner = 0; ownerValid = 1'b0; stbCount = 0;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (!monitorOn) begin
                prevGrant  = grant_o;
                ownerValid = 1'b0;
                grantQ.delete();
                respQ.delete();
            end else begin
                if (grant_o !== prevGrant && grant_o != '0) begin
                    checkOutput("grant_gap", prevGrant, '0);
                    if (grantQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL grant_unexpected: actual %b, required none", grant_o);
                    end else begin
                        g = grantQ.pop_front();
                        checkOutput("grant", grant_o, g.onehot);
                        if (g.checkLat) checkOutput("grant_latency", cycleNo - g.reqCycle, 1);
                        for (int k = 0; k < NM; k++) if (g.onehot[k]) curOwner = k;
                        ownerValid = 1'b1;
                        stbCount   = 0;
                    end
                end
                prevGrant = grant_o;
                if (s_cyc_o === 1'b1) begin
                    if (ownerValid)
                        checkOutput("slave_req", {s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o},
                                    {mAdr[curOwner], mDat[curOwner], mWe[curOwner], mSel[curOwner], 1'b1});
                    if (s_stb_o) stbCount++;
                end
                if (grant_o == '0 && !timeout_o)
                    checkOutput("idle_bus", {s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
                                             m_ack_o, m_err_o, m_rty_o}, '0);
                if ((m_ack_o | m_err_o | m_rty_o) != '0 || timeout_o) begin
                    if (respQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL resp_unexpected: actual ack %b err %b rty %b tmo %b, required none",
                                 m_ack_o, m_err_o, m_rty_o, timeout_o);
                    end else begin
                        r = respQ.pop_front();
                        checkOutput("resp", {m_ack_o, m_err_o, m_rty_o, timeout_o, s_cyc_o},
                                    {r.ack, r.err, r.rty, r.tmo, r.sCyc});
                        if (r.ack != '0) checkOutput("rdata", m_dat_o, r.dat);
                        if (r.tmo) checkOutput("tmo_cycle", stbCount, TMO);
                    end
                end
            end
        end
    end

    // Main stimulus: reset checks, directed batches, random batches, reset mid-transfer
    initial begin
        rst = 1'b1; pending = '0; respSeen = '0; stallCnt = 0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
        monitorOn = 1'b0; slaveOn = 1'b0; modelLast = NM - 1;
        for (int i = 0; i < NM; i++) setMaster(i, '0, '0, 1'b0, '0, 0, 0, '0);

        repeat (2) @(posedge clk);
        #1;
        s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
        @(negedge clk);
        checkOutput("reset_state", {grant_o, timeout_o, s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_sel_o,
                                    s_dat_o, m_ack_o, m_err_o, m_rty_o}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        monitorOn = 1'b1; slaveOn = 1'b1;
        repeat (2) stepCycle();

        for (int i = 0; i < NM; i++) setMaster(i, $urandom, $urandom, 1'b0, 4'hF, 0, i % 3, $urandom);
        applyStimulus(4'b1111);
        setMaster(0, $urandom, $urandom, 1'b1, 4'h1, 0, 0, $urandom);
        applyStimulus(4'b0001);

        setMaster(1, $urandom, $urandom, 1'b0, 4'hF, 0, 2, 32'hCAFEF00D);
        applyStimulus(4'b0010);

        setMaster(2, 32'h1000, $urandom, 1'b1, 4'hF, 1, 1, $urandom);
        setMaster(0, 32'hFFFF, $urandom, 1'b0, 4'h3, 0, 0, $urandom);
        applyStimulus(4'b0101);

        setMaster(3, $urandom, $urandom, 1'b1, 4'hC, 0, NEVER, $urandom);
        setMaster(0, $urandom, $urandom, 1'b0, 4'hF, 0, 1, $urandom);
        applyStimulus(4'b1001);

        setMaster(1, $urandom, $urandom, 1'b0, 4'hF, 2, 0, $urandom);
        setMaster(2, $urandom, $urandom, 1'b0, 4'hF, 0, TMO - 1, $urandom);
        applyStimulus(4'b0110);

        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < NM; i++) randomMaster(i);
            applyStimulus(NM'($urandom_range(1, (1 << NM) - 1)));
        end

        begin : midReset
            grantT g;
            int    budget;
            setMaster(1, $urandom, $urandom, 1'b0, 4'hF, 0, NEVER, $urandom);
            g.onehot = 4'b0010; g.reqCycle = cycleNo + 1; g.checkLat = 1'b1;
            grantQ.push_back(g);
            pending = 4'b0010;
            budget = 0;
            while (grant_o != 4'b0010 && budget < 10) begin
                stepCycle();
                budget++;
            end
            checkOutput("midrst_grant", grant_o, 4'b0010);
            stepCycle();
            monitorOn = 1'b0;
            slaveOn   = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            s_ack_i = 1'b1;
            @(posedge clk);
            #2;
            checkOutput("midrst_bus", {grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o}, '0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            s_ack_i = 1'b0;
            pending = '0;
            respSeen = '0;
            repeat (2) stepCycle();
            modelLast = NM - 1;
            monitorOn = 1'b1;
            slaveOn   = 1'b1;
            setMaster(0, $urandom, $urandom, 1'b0, 4'hF, 0, 1, $urandom);
            setMaster(1, $urandom, $urandom, 1'b1, 4'hF, 0, 0, $urandom);
            applyStimulus(4'b0011);
        end

        repeat (3) stepCycle();
        checkOutput("grantQ_drained", grantQ.size(), 0);
        checkOutput("respQ_drained", respQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
